tick_timer: RTL and testbench

- Parametrised successor to the 50 MHz → 1 Hz divider: a programmable-period prescaler plus a loadable seconds countdown.
- Provides a one-shot or periodic mode, a done pulse and a 50 % square-wave output that stays compatible with the existing clk_1Hz consumers.
- Sits between the board clock and the traffic-light FSMs, which load phase durations (red/yellow/green seconds) and wait for done.

---
 rtl/timer_pkg.sv | 28 ++
 rtl/tick_prescaler.sv | 47 ++++
 rtl/tick_timer.sv | 106 ++++++++++
 tb/tb_tick_timer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
//  timer_pkg : shared state encoding, mode constants and prescaler sizing
//  Revision  : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    function automatic int presc_calc(input int clk_hz, input int tick_hz);
        return (tick_hz > 0) ? (clk_hz / tick_hz) : 0;
    endfunction

    // A 2-count prescaler still needs one bit, so clamp the width at 1.
    function automatic int presc_width(input int presc);
        return (presc < 2) ? 1 : $clog2(presc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  tick_prescaler : free-running 0..PRESC-1 counter with tick and square wave
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tick_prescaler
    import timer_pkg::*;
#(
    parameter int PRESC = 10
) (
    input  logic clk_50MHz,
    input  logic res,
    input  logic sync_clr,
    output logic tick,
    output logic clk_1Hz
);

    localparam int            CNT_W  = presc_width(PRESC);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PRESC - 1);
    localparam logic [CNT_W-1:0] C_HALF = CNT_W'(PRESC / 2);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (sync_clr || (cnt_q == C_LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_50MHz or posedge res) begin
        if (res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Both outputs are pure decodes of the count register.
    assign tick    = (cnt_q == C_LAST);
    assign clk_1Hz = (cnt_q < C_HALF);

endmodule

`default_nettype wire

// File: rtl/tick_timer.sv
// ============================================================================
//  tick_timer : programmable prescaler plus loadable one-shot/periodic countdown
//  Revision   : 1.0
// ============================================================================
`default_nettype none

module tick_timer
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1,
    parameter int SEC_W   = 8
) (
    input  logic             clk_50MHz,
    input  logic             res,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [SEC_W-1:0] load_val,
    output logic             tick,
    output logic             clk_1Hz,
    output logic [SEC_W-1:0] remaining,
    output logic             busy,
    output logic             done
);

    localparam int PRESC = presc_calc(CLK_HZ, TICK_HZ);

    generate
        if ((TICK_HZ <= 0) || ((CLK_HZ % TICK_HZ) != 0) || (PRESC < 2)) begin : g_bad_presc
            $error("tick_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
        end
    endgenerate

    state_e           state_q;
    logic [SEC_W-1:0] remaining_q;
    logic [SEC_W-1:0] load_q;
    logic             mode_q;
    logic             busy_q;
    logic             done_q;
    logic             sync_clr;

    // stop outranks start, so a start that collides with stop must not
    // disturb the prescaler phase.
    assign sync_clr = start && !stop;

    tick_prescaler #(
        .PRESC (PRESC)
    ) u_prescaler (
        .clk_50MHz (clk_50MHz),
        .res       (res),
        .sync_clr  (sync_clr),
        .tick      (tick),
        .clk_1Hz   (clk_1Hz)
    );

    always_ff @(posedge clk_50MHz or posedge res) begin
        if (res) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            load_q      <= '0;
            mode_q      <= MODE_ONESHOT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q     <= IDLE;
                remaining_q <= '0;
                busy_q      <= 1'b0;
            end else if (start) begin
                load_q <= load_val;
                mode_q <= mode;
                if (load_val == '0) begin
                    state_q     <= IDLE;
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end else begin
                    state_q     <= RUN;
                    remaining_q <= load_val;
                    busy_q      <= 1'b1;
                end
            end else if ((state_q == RUN) && tick) begin
                if (remaining_q > SEC_W'(1)) begin
                    remaining_q <= remaining_q - SEC_W'(1);
                end else if (mode_q == MODE_PERIODIC) begin
                    remaining_q <= load_q;
                    done_q      <= 1'b1;
                end else begin
                    state_q     <= IDLE;
                    remaining_q <= '0;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                end
            end
        end
    end

    assign remaining = remaining_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ============================================================================
//  tb_tick_timer : directed self-checking bench for tick_timer (PRESC = 10)
//  Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_tick_timer;

    localparam int SEC_W = 4;

    logic             clk_50MHz = 1'b0;
    logic             res       = 1'b1;
    logic             start     = 1'b0;
    logic             stop      = 1'b0;
    logic             mode      = 1'b0;
    logic [SEC_W-1:0] load_val  = '0;
    logic             tick;
    logic             clk_1Hz;
    logic [SEC_W-1:0] remaining;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    tick_timer #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .SEC_W   (SEC_W)
    ) dut (
        .clk_50MHz (clk_50MHz),
        .res       (res),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .load_val  (load_val),
        .tick      (tick),
        .clk_1Hz   (clk_1Hz),
        .remaining (remaining),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle 1 ns past it.
    task automatic steps(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [SEC_W-1:0] lv, input logic md);
        start    = 1'b1;
        load_val = lv;
        mode     = md;
        steps(1);
        start    = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_busy", busy, 0);
        check("rst_rem", remaining, 0);
        check("rst_done", done, 0);
        check("rst_tick", tick, 0);
        check("rst_clk1hz", clk_1Hz, 1);
        steps(2);
        res = 1'b0;

        // Free-running prescaler: this cycle is count 0
        for (int i = 0; i < 40; i++) begin
            check($sformatf("idle_tick_%0d", i), tick, ((i % 10) == 9) ? 1 : 0);
            check($sformatf("idle_sq_%0d", i), clk_1Hz, ((i % 10) < 5) ? 1 : 0);
            steps(1);
        end
        check("idle_rem", remaining, 0);
        check("idle_busy", busy, 0);

        // One-shot, load 3
        pulse_start(4'd3, 1'b0);
        check("os_busy0", busy, 1);
        check("os_rem0", remaining, 3);
        steps(9);
        check("os_rem9", remaining, 3);
        steps(1);
        check("os_rem10", remaining, 2);
        steps(10);
        check("os_rem20", remaining, 1);
        steps(9);
        check("os_done29", done, 0);
        steps(1);
        check("os_done30", done, 1);
        check("os_rem30", remaining, 0);
        check("os_busy30", busy, 0);
        steps(1);
        check("os_done31", done, 0);

        // Periodic, load 2
        pulse_start(4'd2, 1'b1);
        check("per_rem0", remaining, 2);
        steps(10);
        check("per_rem10", remaining, 1);
        steps(9);
        check("per_done19", done, 0);
        steps(1);
        check("per_done20", done, 1);
        check("per_rem20", remaining, 2);
        check("per_busy20", busy, 1);
        steps(1);
        check("per_done21", done, 0);
        steps(19);
        check("per_done40", done, 1);
        check("per_rem40", remaining, 2);
        steps(20);
        check("per_done60", done, 1);
        check("per_busy60", busy, 1);
        steps(1);
        check("per_done61", done, 0);

        // stop collides with the decrementing tick
        pulse_start(4'd5, 1'b0);
        steps(9);
        check("stp_tick9", tick, 1);
        check("stp_rem9", remaining, 5);
        stop = 1'b1;
        steps(1);
        stop = 1'b0;
        check("stp_busy", busy, 0);
        check("stp_rem", remaining, 0);
        check("stp_done", done, 0);
        steps(1);
        check("stp_done_next", done, 0);
        // start and stop together: stop wins, prescaler phase untouched
        start    = 1'b1;
        stop     = 1'b1;
        load_val = 4'd5;
        steps(1);
        start = 1'b0;
        stop  = 1'b0;
        check("ss_busy", busy, 0);
        check("ss_rem", remaining, 0);
        check("ss_tick_early", tick, 0);
        steps(7);
        check("ss_tick_phase", tick, 1);

        // Zero load gives an immediate done
        pulse_start(4'd0, 1'b0);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_rem", remaining, 0);
        steps(1);
        check("z_done_next", done, 0);

        // Restart while running
        pulse_start(4'd5, 1'b0);
        steps(14);
        check("rs_rem14", remaining, 4);
        start    = 1'b1;
        load_val = 4'd7;
        steps(1);
        start = 1'b0;
        check("rs_rem15", remaining, 7);
        check("rs_busy15", busy, 1);
        check("rs_done15", done, 0);
        steps(9);
        check("rs_rem24", remaining, 7);
        steps(1);
        check("rs_rem25", remaining, 6);

        // Asynchronous reset between edges
        steps(3);
        #3;
        res = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_rem", remaining, 0);
        check("ar_done", done, 0);
        check("ar_tick", tick, 0);
        check("ar_clk1hz", clk_1Hz, 1);
        @(posedge clk_50MHz);
        #2;
        res = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk_50MHz);
            #1;
            check($sformatf("ar_tick_%0d", i), tick, (i == 9) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
